// File: rtl/mem_walker_stride_nd.sv
// mem_walker_stride_nd: nested-loop strided address generator with per-group stride/iteration tables
module mem_walker_stride_nd #(
  parameter int ADDR_WIDTH    = 48,
  parameter int ADDR_STRIDE_W = 16,
  parameter int ITER_W        = 16,
  parameter int LOOP_ID_W     = 3,
  parameter int GROUP_ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [GROUP_ID_W-1:0]    cfg_group_id,
  input  logic [LOOP_ID_W-1:0]     cfg_loop_id,
  input  logic                     cfg_stride_v,
  input  logic [ADDR_STRIDE_W-1:0] cfg_stride,
  input  logic                     cfg_iter_v,
  input  logic [ITER_W-1:0]        cfg_iter,
  input  logic                     start,
  input  logic [GROUP_ID_W-1:0]    start_group_id,
  input  logic [LOOP_ID_W:0]       start_num_loops,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     abort,
  output logic [ADDR_WIDTH-1:0]    addr_out,
  output logic                     addr_out_valid,
  input  logic                     addr_out_ready,
  output logic                     addr_out_last,
  output logic                     busy,
  output logic                     done
);
  localparam int NL = 2 ** LOOP_ID_W;
  localparam int NG = 2 ** GROUP_ID_W;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDR_STRIDE_W-1:0] stride [NG][NL];
  logic [ITER_W-1:0]        iter   [NG][NL];
  logic [ITER_W-1:0]        count  [NL];
  logic [ADDR_WIDTH-1:0]    lvl    [NL];
  logic [GROUP_ID_W-1:0]    grp;
  logic [LOOP_ID_W:0]       nl, n_start;
  logic [LOOP_ID_W-1:0]     sel;
  logic [ADDR_WIDTH-1:0]    nxt_addr;
  logic                     found, hs, go, step, fin, cfg_ok, done_r;
  assign go       = state == IDLE && start;
  assign hs       = state == RUN && addr_out_ready;
  assign step     = hs && !abort && found;
  assign fin      = hs && !abort && !found;
  assign cfg_ok   = !(state == RUN && cfg_group_id == grp);
  assign n_start  = start_num_loops == '0 ? (LOOP_ID_W+1)'(1) :
                    start_num_loops > (LOOP_ID_W+1)'(NL) ? (LOOP_ID_W+1)'(NL) : start_num_loops;
  assign nxt_addr = lvl[sel] + ADDR_WIDTH'(signed'(stride[grp][sel]));
  // lowest active loop that still has iterations left; none found means this is the last address
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NL; i++)
      if (!found && (LOOP_ID_W+1)'(i) < nl && count[i] < iter[grp][i]) begin
        found = 1'b1;
        sel   = LOOP_ID_W'(i);
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start ? RUN : IDLE) : (abort || fin) ? IDLE : RUN;
  always_comb begin
    busy           = state == RUN;
    addr_out_valid = state == RUN;
    addr_out_last  = state == RUN && !found;
    addr_out       = lvl[0];
    done           = done_r;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      done_r <= 1'b0;
      grp    <= '0;
      nl     <= '0;
      for (int g = 0; g < NG; g++)
        for (int i = 0; i < NL; i++) begin
          stride[g][i] <= '0;
          iter[g][i]   <= '0;
        end
      for (int i = 0; i < NL; i++) begin
        count[i] <= '0;
        lvl[i]   <= '0;
      end
    end else begin
      done_r <= fin;
      if (cfg_stride_v && cfg_ok) stride[cfg_group_id][cfg_loop_id] <= cfg_stride;
      if (cfg_iter_v && cfg_ok)   iter[cfg_group_id][cfg_loop_id]   <= cfg_iter;
      if (go) begin
        grp <= start_group_id;
        nl  <= n_start;
        for (int i = 0; i < NL; i++) begin
          count[i] <= '0;
          lvl[i]   <= base_addr;
        end
      end else if (step)
        for (int i = 0; i < NL; i++)
          if (LOOP_ID_W'(i) == sel) begin
            count[i] <= count[i] + ITER_W'(1);
            lvl[i]   <= nxt_addr;
          end else if (LOOP_ID_W'(i) < sel) begin
            count[i] <= '0;
            lvl[i]   <= nxt_addr;
          end
    end
endmodule

// File: tb/tb_mem_walker_stride_nd.sv
// tb_mem_walker_stride_nd: directed bench with an enumerating address model and per-cycle compare
module tb_mem_walker_stride_nd;
  logic        clk = 0, reset = 1;
  logic [1:0]  cfg_group_id = 0, start_group_id = 0;
  logic [2:0]  cfg_loop_id = 0;
  logic        cfg_stride_v = 0, cfg_iter_v = 0, start = 0, abort = 0, addr_out_ready = 1;
  logic [15:0] cfg_stride = 0, cfg_iter = 0;
  logic [3:0]  start_num_loops = 0;
  logic [47:0] base_addr = 0, addr_out;
  logic        addr_out_valid, addr_out_last, busy, done;

  mem_walker_stride_nd dut (
    .clk(clk), .reset(reset), .cfg_group_id(cfg_group_id), .cfg_loop_id(cfg_loop_id),
    .cfg_stride_v(cfg_stride_v), .cfg_stride(cfg_stride), .cfg_iter_v(cfg_iter_v),
    .cfg_iter(cfg_iter), .start(start), .start_group_id(start_group_id),
    .start_num_loops(start_num_loops), .base_addr(base_addr), .abort(abort),
    .addr_out(addr_out), .addr_out_valid(addr_out_valid), .addr_out_ready(addr_out_ready),
    .addr_out_last(addr_out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int asserts = 0, fails = 0;
  logic [15:0] ms [4][8];
  logic [15:0] mi [4][8];
  logic [47:0] q[$], got[$], exp_q[$];
  logic [1:0]  mgrp = 0;
  logic        exp_done = 0, prev_stall = 0, prev_last = 0, was_busy;
  logic [47:0] prev_addr = 0;

  function void chk(string nm, logic [63:0] act, logic [63:0] req);
    asserts++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void clear_model();
    for (int g = 0; g < 4; g++)
      for (int l = 0; l < 8; l++) begin
        ms[g][l] = 0;
        mi[g][l] = 0;
      end
    q.delete();
    exp_done = 0;
    prev_stall = 0;
  endfunction

  // every address of the walk enumerated as base + sum(count[l]*stride[l]), loop 0 fastest
  function automatic void build(logic [1:0] g, logic [3:0] n_in, logic [47:0] base);
    int n = n_in == 0 ? 1 : (n_in > 8 ? 8 : int'(n_in));
    longint total = 1;
    for (int l = 0; l < n; l++) total *= longint'(mi[g][l]) + 1;
    for (longint k = 0; k < total; k++) begin
      longint idx = k;
      logic [47:0] a = base;
      for (int l = 0; l < n; l++) begin
        longint r = longint'(mi[g][l]) + 1;
        a = a + 48'(idx % r) * {{32{ms[g][l][15]}}, ms[g][l]};
        idx = idx / r;
      end
      q.push_back(a);
    end
    mgrp = g;
  endfunction

  always @(negedge clk) begin
    if (!reset) clear_model();
    else begin
      chk("valid", 64'(addr_out_valid), 64'(q.size() != 0));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("done", 64'(done), 64'(exp_done));
      if (q.size() != 0) begin
        chk("addr", 64'(addr_out), 64'(q[0]));
        chk("last", 64'(addr_out_last), 64'(q.size() == 1));
      end
      if (prev_stall && addr_out_valid) begin
        chk("stall_addr", 64'(addr_out), 64'(prev_addr));
        chk("stall_last", 64'(addr_out_last), 64'(prev_last));
      end
      prev_stall = addr_out_valid && !addr_out_ready;
      prev_addr = addr_out;
      prev_last = addr_out_last;
      exp_done = 0;
      was_busy = q.size() != 0;
      if (cfg_stride_v && !(was_busy && cfg_group_id == mgrp)) ms[cfg_group_id][cfg_loop_id] = cfg_stride;
      if (cfg_iter_v && !(was_busy && cfg_group_id == mgrp))   mi[cfg_group_id][cfg_loop_id] = cfg_iter;
      if (was_busy && abort) q.delete();
      else if (was_busy && addr_out_ready) begin
        got.push_back(q[0]);
        void'(q.pop_front());
        exp_done = q.size() == 0;
      end else if (!was_busy && start) build(start_group_id, start_num_loops, base_addr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] g, input logic [2:0] l, input logic [15:0] s, input logic sv,
                    input logic [15:0] it, input logic iv);
    cfg_group_id = g; cfg_loop_id = l; cfg_stride = s; cfg_stride_v = sv; cfg_iter = it; cfg_iter_v = iv;
    cyc();
    cfg_stride_v = 0; cfg_iter_v = 0;
  endtask

  task automatic go(input logic [1:0] g, input logic [3:0] n, input logic [47:0] base);
    got.delete();
    start_group_id = g; start_num_loops = n; base_addr = base; start = 1;
    cyc();
    start = 0;
  endtask

  task automatic wait_idle(input bit rnd);
    for (int i = 0; i < 400; i++) begin
      addr_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      if (!busy) begin
        addr_out_ready = 1;
        return;
      end
    end
    chk("walk_timeout", 64'(busy), 64'(0));
    addr_out_ready = 1;
  endtask

  task automatic chk_seq(string nm);
    chk({nm, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, 64'(got[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #2 reset = 0;
    #1;
    chk("rst_valid", 64'(addr_out_valid), 0);
    chk("rst_addr", 64'(addr_out), 0);
    chk("rst_busy", 64'(busy), 0);
    repeat (2) cyc();
    reset = 1;
    cyc();
    abort = 1;
    cyc();
    abort = 0;
    chk("abort_idle", 64'(busy), 0);
    wr(0, 0, 16'd4, 1, 16'd3, 1);
    go(0, 1, 48'h100);
    wait_idle(0);
    chk("t025_done", 64'(done), 1);
    exp_q = '{48'h100, 48'h104, 48'h108, 48'h10C};
    chk_seq("t025");
    go(0, 0, 48'h200);
    wait_idle(0);
    exp_q = '{48'h200, 48'h204, 48'h208, 48'h20C};
    chk_seq("nl0");
    wr(0, 0, 16'd1, 1, 16'd1, 1);
    wr(0, 1, 16'd16, 1, 16'd2, 1);
    go(0, 2, 48'h0);
    start_group_id = 1; base_addr = 48'h999; start = 1;
    cyc();
    start = 0;
    wait_idle(0);
    exp_q = '{48'h0, 48'h1, 48'h10, 48'h11, 48'h20, 48'h21};
    chk_seq("t026");
    go(0, 2, 48'h0);
    wait_idle(1);
    chk_seq("t028");
    wr(0, 0, 16'hFFF8, 1, 16'd2, 1);
    go(0, 1, 48'h8);
    wait_idle(0);
    exp_q = '{48'h8, 48'h0, 48'hFFFF_FFFF_FFF8};
    chk_seq("t027");
    go(0, 4'd12, 48'h40);
    wait_idle(0);
    wr(1, 0, 16'd2, 1, 16'd9, 1);
    go(1, 1, 48'h0);
    wr(2, 0, 16'd5, 1, 16'd1, 1);
    wr(1, 0, 16'd100, 1, 16'd0, 1);
    abort = 1;
    cyc();
    abort = 0;
    chk("abort_valid", 64'(addr_out_valid), 0);
    chk("abort_done", 64'(done), 0);
    cyc();
    chk("abort_nodone", 64'(done), 0);
    go(1, 1, 48'h0);
    wait_idle(0);
    exp_q = '{48'd0, 48'd2, 48'd4, 48'd6, 48'd8, 48'd10, 48'd12, 48'd14, 48'd16, 48'd18};
    chk_seq("t029_g1");
    go(2, 1, 48'h10);
    wait_idle(0);
    exp_q = '{48'h10, 48'h15};
    chk_seq("t029_g2");
    wr(0, 0, 16'd3, 1, 16'd7, 1);
    go(0, 1, 48'h500);
    cyc();
    cyc();
    #2 reset = 0;
    #1;
    chk("t030_valid", 64'(addr_out_valid), 0);
    chk("t030_last", 64'(addr_out_last), 0);
    chk("t030_busy", 64'(busy), 0);
    chk("t030_done", 64'(done), 0);
    chk("t030_addr", 64'(addr_out), 0);
    cyc();
    cyc();
    reset = 1;
    cyc();
    go(0, 1, 48'h55);
    chk("t030_first", 64'(addr_out), 64'h55);
    chk("t030_lastflag", 64'(addr_out_last), 1);
    wait_idle(0);
    exp_q = '{48'h55};
    chk_seq("t030");
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
